// File: rtl/riscv_div_pkg.sv
// Shared types and constants for the RV32M iterative divider.
package riscv_div_pkg;

    // One quotient bit is produced per iteration; RV32 needs 32 of them.
    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_t;

    // DIV and REM treat their operands as two's complement.
    function automatic logic is_signed_op(input div_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/riscv_div_unit_div_step.sv
// One restoring radix-2 iteration: shift {rem, quo} left, trial-subtract the divisor.
module riscv_div_unit_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] diff;
    logic            fits;

    // Trial subtraction; a set top remainder bit means the shifted value
    // exceeds the divisor regardless of the borrow out of the low bits.
    always_comb begin
        rem_sh = {rem_in[XLEN-1:0], quo_in[XLEN-1]};
        diff   = {1'b0, rem_sh} - {2'b00, divisor};
        fits   = ~diff[XLEN+1] | rem_in[XLEN];
        if (fits) begin
            rem_out = diff[XLEN:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = rem_sh;
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/riscv_div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: 32 restoring iterations, a sign-fix cycle,
// then a one-cycle register-file write-back. Special cases finish in one cycle.
module riscv_div_unit
    import riscv_div_pkg::*;
#(
    parameter int XLEN = DIV_ITER
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            wer,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] regdata
);

    localparam int               CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    // Two's complement negate when requested; used for magnitudes and sign fix-up.
    function automatic logic [XLEN-1:0] negate_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]    rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvsr_q, dvsr_d;
    div_op_t          op_q, op_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic [4:0]       rd_q, rd_d;
    logic [XLEN-1:0]  regdata_q, regdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wer_q, wer_d;

    logic [XLEN:0]    step_rem;
    logic [XLEN-1:0]  step_quo;

    div_op_t          op_in;
    logic             in_signed;
    logic             div_zero;
    logic             ovf;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             fix_signed;
    logic [XLEN-1:0]  fix_quo;
    logic [XLEN-1:0]  fix_rem;
    logic [XLEN-1:0]  fix_result;

    riscv_div_unit_div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvsr_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Operand decode at issue and sign correction of the finished quotient/remainder.
    always_comb begin
        op_in      = div_op_t'(op);
        in_signed  = is_signed_op(op_in);
        div_zero   = (rs2_val == '0);
        ovf        = in_signed && (rs1_val == INT_MIN) && (rs2_val == '1);
        a_mag      = negate_if(in_signed & rs1_val[XLEN-1], rs1_val);
        b_mag      = negate_if(in_signed & rs2_val[XLEN-1], rs2_val);
        fix_signed = is_signed_op(op_q);
        fix_quo    = negate_if(fix_signed & (a_neg_q ^ b_neg_q), quo_q);
        fix_rem    = negate_if(fix_signed & a_neg_q, rem_q[XLEN-1:0]);
        fix_result = (op_q == REM || op_q == REMU) ? fix_rem : fix_quo;
    end

    // Next-state and datapath update; flush overrides everything but the held result.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        op_d      = op_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        rd_d      = rd_q;
        regdata_d = regdata_q;
        done_d    = 1'b0;
        wer_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d    = op_in;
                    rd_d    = rd_in;
                    a_neg_d = rs1_val[XLEN-1];
                    b_neg_d = rs2_val[XLEN-1];
                    if (div_zero) begin
                        regdata_d = op[1] ? rs1_val : '1;
                        state_d   = DONE;
                        done_d    = 1'b1;
                        wer_d     = (rd_in != 5'd0);
                    end else if (ovf) begin
                        regdata_d = op[1] ? '0 : rs1_val;
                        state_d   = DONE;
                        done_d    = 1'b1;
                        wer_d     = (rd_in != 5'd0);
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_mag;
                        dvsr_d  = b_mag;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                regdata_d = fix_result;
                state_d   = DONE;
                done_d    = 1'b1;
                wer_d     = (rd_q != 5'd0);
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d   = IDLE;
            cnt_d     = '0;
            done_d    = 1'b0;
            wer_d     = 1'b0;
            regdata_d = regdata_q;
        end

        busy_d = (state_d != IDLE);
    end

    // Control and architecturally visible registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wer_q     <= 1'b0;
            rd_q      <= '0;
            regdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wer_q     <= wer_d;
            rd_q      <= rd_d;
            regdata_q <= regdata_d;
        end
    end

    // Working datapath registers; only meaningful while an operation is in flight.
    always_ff @(posedge clk) begin
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        dvsr_q  <= dvsr_d;
        op_q    <= op_d;
        a_neg_q <= a_neg_d;
        b_neg_q <= b_neg_d;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wer     = wer_q;
    assign rd      = rd_q;
    assign regdata = regdata_q;

endmodule
